// File: rtl/seq_serial_adder.sv
// Multi-cycle add/subtract unit: processes DIGIT bits per clock with one carry
// flip-flop behind a start/busy/done handshake.
module seq_serial_adder #(
  parameter int WIDTH  = 8,
  parameter int DIGIT  = 1,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | one digit per clock, N clocks
  // DONE  | results just updated; start here chains the next operation
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);

  state_t           state, state_nxt;
  logic             load, step, last;
  logic [WIDTH-1:0] areg, breg, psum, psum_nxt;
  logic             carry, sub_q, cin_msb;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   dsum;

  assign dsum = {1'b0, areg[DIGIT-1:0]} + {1'b0, breg[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
  assign last = (cnt == CW'(N - 1));

  // Carry into the top bit of the digit, recovered from that bit's sum and operands.
  assign cin_msb = dsum[DIGIT-1] ^ areg[DIGIT-1] ^ breg[DIGIT-1];

  generate
    if (DIGIT == WIDTH) begin : g_single
      assign psum_nxt = dsum[DIGIT-1:0];
    end else begin : g_multi
      assign psum_nxt = {dsum[DIGIT-1:0], psum[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      areg  <= '0;
      breg  <= '0;
      psum  <= '0;
      carry <= 1'b0;
      sub_q <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        areg  <= a;
        breg  <= sub ? ~b : b;
        carry <= sub ? ~cin : cin;
        sub_q <= sub;
        cnt   <= '0;
      end else if (step) begin
        carry <= dsum[DIGIT];
        psum  <= psum_nxt;
        areg  <= areg >> DIGIT;
        breg  <= breg >> DIGIT;
        cnt   <= cnt + CW'(1);
        if (last) begin
          s    <= psum_nxt;
          cout <= sub_q ^ dsum[DIGIT];
          ovf  <= (SIGNED != 0) ? (cin_msb ^ dsum[DIGIT]) : (sub_q ^ dsum[DIGIT]);
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_serial_adder.sv
// Bench for seq_serial_adder: three instances (8/1 signed, 8/1 unsigned, 8/4 signed)
// checked against an integer-arithmetic reference model.
module tb_seq_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start8 = 1'b0, start4 = 1'b0;
  logic [7:0] a_i = '0, b_i = '0;
  logic       cin_i = 1'b0, sub_i = 1'b0;

  logic       busy_w [3];
  logic       done_w [3];
  logic [7:0] s_w    [3];
  logic       cout_w [3];
  logic       ovf_w  [3];

  int checks = 0;
  int errors = 0;
  int dcount = 0;

  always #5 clk = ~clk;

  seq_serial_adder #(.WIDTH(8), .DIGIT(1), .SIGNED(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a_i), .b(b_i), .cin(cin_i), .sub(sub_i),
    .busy(busy_w[0]), .done(done_w[0]), .s(s_w[0]), .cout(cout_w[0]), .ovf(ovf_w[0]));

  seq_serial_adder #(.WIDTH(8), .DIGIT(1), .SIGNED(0)) u_u1 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a_i), .b(b_i), .cin(cin_i), .sub(sub_i),
    .busy(busy_w[1]), .done(done_w[1]), .s(s_w[1]), .cout(cout_w[1]), .ovf(ovf_w[1]));

  seq_serial_adder #(.WIDTH(8), .DIGIT(4), .SIGNED(1)) u_s4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a_i), .b(b_i), .cin(cin_i), .sub(sub_i),
    .busy(busy_w[2]), .done(done_w[2]), .s(s_w[2]), .cout(cout_w[2]), .ovf(ovf_w[2]));

  always @(posedge clk) if (done_w[0] === 1'b1) dcount++;

  // Reference result as {ovf, cout, s} from plain integer arithmetic.
  function automatic logic [9:0] ref_op(input bit sgn, input logic [7:0] ta, input logic [7:0] tb,
                                        input logic tc, input logic ts);
    int u, sa, sb, sv;
    logic c, o;
    logic [7:0] r;
    sa = int'(ta) - (ta[7] ? 256 : 0);
    sb = int'(tb) - (tb[7] ? 256 : 0);
    if (ts) begin
      u  = int'(ta) - int'(tb) - int'(tc);
      sv = sa - sb - int'(tc);
      c  = (u < 0);
    end else begin
      u  = int'(ta) + int'(tb) + int'(tc);
      sv = sa + sb + int'(tc);
      c  = (u > 255);
    end
    r = 8'((u + 512) % 256);
    o = sgn ? ((sv > 127) || (sv < -128)) : c;
    return {o, c, r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int g, input logic v);
    if (g == 0) start8 = v; else start4 = v;
  endtask

  task automatic drive(input int g, input logic [7:0] ta, input logic [7:0] tb,
                       input logic tc, input logic ts);
    a_i = ta; b_i = tb; cin_i = tc; sub_i = ts;
    set_start(g, 1'b1);
  endtask

  task automatic scramble();
    a_i = 8'($urandom); b_i = 8'($urandom); cin_i = 1'($urandom); sub_i = 1'($urandom);
  endtask

  // Called at the negedge just after the accepting edge; returns at the negedge where done is high.
  task automatic wait_done(input int g, input int n, input bit poke);
    int lat, bcnt, idx;
    idx = (g == 0) ? 0 : 2;
    lat = 0; bcnt = 0;
    while (done_w[idx] !== 1'b1 && lat < 40) begin
      if (busy_w[idx] === 1'b1) bcnt++;
      if (poke && lat == 2) begin scramble(); set_start(g, 1'b1); end
      if (poke && lat == 3) set_start(g, 1'b0);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, n);
    chk("busy_cycles", bcnt, n);
    chk("busy_at_done", busy_w[idx], 1'b0);
  endtask

  task automatic check_res(input int g, input logic [7:0] ta, input logic [7:0] tb,
                           input logic tc, input logic ts);
    logic [9:0] e;
    for (int k = 0; k < 3; k++) begin
      if ((g == 0 && k < 2) || (g == 1 && k == 2)) begin
        e = ref_op(k != 1, ta, tb, tc, ts);
        chk($sformatf("s[%0d] %h%s%h c%0d", k, ta, ts ? "-" : "+", tb, tc), s_w[k], e[7:0]);
        chk($sformatf("cout[%0d]", k), cout_w[k], e[8]);
        chk($sformatf("ovf[%0d]", k), ovf_w[k], e[9]);
      end
    end
  endtask

  task automatic run_op(input int g, input logic [7:0] ta, input logic [7:0] tb,
                        input logic tc, input logic ts, input bit poke);
    @(negedge clk);
    drive(g, ta, tb, tc, ts);
    @(negedge clk);
    set_start(g, 1'b0);
    scramble();
    wait_done(g, (g == 0) ? 8 : 2, poke);
    check_res(g, ta, tb, tc, ts);
    @(negedge clk);
    chk("done_one_cycle", done_w[(g == 0) ? 0 : 2], 1'b0);
  endtask

  int dstart;

  initial begin
    // Reset with start asserted: reset must win.
    start8 = 1'b1; start4 = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_busy", busy_w[k], 1'b0);
      chk("rst_done", done_w[k], 1'b0);
      chk("rst_s", s_w[k], 8'h00);
      chk("rst_cout_ovf", {cout_w[k], ovf_w[k]}, 2'b00);
    end
    start8 = 1'b0; start4 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    run_op(0, 8'h5A, 8'h3C, 1'b0, 1'b0, 0);
    run_op(0, 8'h10, 8'h20, 1'b0, 1'b1, 0);
    run_op(0, 8'hFF, 8'h01, 1'b1, 1'b0, 0);
    run_op(0, 8'h00, 8'h00, 1'b1, 1'b1, 0);
    run_op(0, 8'h80, 8'h01, 1'b0, 1'b1, 0);
    run_op(0, 8'h7F, 8'h7F, 1'b1, 1'b0, 1);
    run_op(1, 8'h5A, 8'h3C, 1'b0, 1'b0, 0);
    run_op(1, 8'h80, 8'h7F, 1'b1, 1'b1, 0);

    for (int i = 0; i < 20; i++)
      run_op(0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), (i % 4) == 0);
    for (int i = 0; i < 12; i++)
      run_op(1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 0);

    // Back-to-back with start held high; new operands are presented during RUN.
    @(negedge clk);
    dstart = dcount;
    drive(0, 8'h5A, 8'h3C, 1'b0, 1'b0);
    @(negedge clk);
    a_i = 8'h01; b_i = 8'h01;
    wait_done(0, 8, 0);
    check_res(0, 8'h5A, 8'h3C, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b_done_low", done_w[0], 1'b0);
    chk("b2b_busy_high", busy_w[0], 1'b1);
    set_start(0, 1'b0);
    scramble();
    wait_done(0, 8, 0);
    check_res(0, 8'h01, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b_done_pulses", dcount - dstart, 2);

    // Reset during the third RUN cycle aborts the operation.
    drive(0, 8'h33, 8'h44, 1'b0, 1'b0);
    @(negedge clk);
    set_start(0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    dstart = dcount;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("abort_busy", busy_w[k], 1'b0);
      chk("abort_done", done_w[k], 1'b0);
      chk("abort_s", s_w[k], 8'h00);
      chk("abort_cout_ovf", {cout_w[k], ovf_w[k]}, 2'b00);
    end
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_done", dcount - dstart, 0);
    chk("abort_idle", busy_w[0], 1'b0);
    run_op(0, 8'h5A, 8'h3C, 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
